// File: rtl/seq_step_player_pkg.sv
// rtl/seq_step_player_pkg.sv - shared constants and state encoding for the step players
//
// Shared by the clap, kick, snare and hat step players so that every track
// agrees on bar width, step-index width and the IDLE/RUN encoding.
package seq_step_player_pkg;

  // One pattern bit per step; the bar never exceeds the pattern width.
  localparam int NUM_STEPS = 32;
  localparam int STEP_W    = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/seq_trig_stretch.sv
// rtl/seq_trig_stretch.sv - retriggerable fixed-length pulse stretcher
//
// Turns a one-cycle fire strobe into a pulse exactly TRIG_LEN cycles long,
// starting the cycle after fire is sampled.
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   fire   in   start (or restart) the pulse; reloads the full length
//   kill   in   truncate any active pulse; wins over fire
//   pulse  out  registered pulse output
module seq_trig_stretch #(
  parameter int TRIG_LEN = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic fire,
  input  logic kill,
  output logic pulse
);

  localparam int CNT_W = $clog2(TRIG_LEN + 1);

  // Counts the high cycles still owed after the current one.
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || kill) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (fire) begin
      // Reload rather than extend: a retrigger restarts the full length
      // with no low gap in between.
      cnt   <= CNT_W'(TRIG_LEN - 1);
      pulse <= 1'b1;
    end else if (cnt != '0) begin
      cnt   <= cnt - CNT_W'(1);
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_step_player.sv
// rtl/seq_step_player.sv - clap pattern step player with double-buffered pattern
//
// Walks the CPU-written 32-bit pattern one step at a time at a programmable
// tempo and fires a fixed-length trigger for every set bit. The pattern is
// latched into a shadow register only at bar start, so CPU writes never
// change a bar that is already playing.
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   run        in   level: 1 = play, 0 = stop and rewind
//   restart    in   one-cycle pulse: rewind to step 0 while running
//   step_div   in   clk cycles per step minus 1
//   seq_len    in   bar length minus 1
//   pattern    in   live pattern, bit n = step n
//   trig       out  trigger pulse to the voice envelope
//   step_tick  out  one-cycle strobe at the start of each step
//   bar_start  out  one-cycle strobe with the step_tick of step 0
//   step_idx   out  index of the current step
//   running    out  high while playing
module seq_step_player
  import seq_step_player_pkg::*;
#(
  parameter int DIV_WIDTH = 24,
  parameter int TRIG_LEN  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] step_div,
  input  logic [STEP_W-1:0]    seq_len,
  input  logic [NUM_STEPS-1:0] pattern,
  output logic                 trig,
  output logic                 step_tick,
  output logic                 bar_start,
  output logic [STEP_W-1:0]    step_idx,
  output logic                 running
);

  seq_state_t           state;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [NUM_STEPS-1:0] shadow;

  // Decisions for the coming edge.
  logic                 tick_d;
  logic                 stop_d;
  logic [STEP_W-1:0]    idx_d;
  logic [NUM_STEPS-1:0] shadow_d;
  logic                 fire;

  always_comb begin
    tick_d = 1'b0;
    stop_d = 1'b0;
    idx_d  = step_idx;
    case (state)
      ST_IDLE: begin
        if (run) begin
          tick_d = 1'b1;
          idx_d  = '0;
        end
      end
      ST_RUN: begin
        // Stop outranks restart; restart outranks the tempo divider.
        if (!run) begin
          stop_d = 1'b1;
        end else if (restart) begin
          tick_d = 1'b1;
          idx_d  = '0;
        end else if (div_cnt >= step_div) begin
          // >= rather than == so a step_div lowered mid-step ends the step
          // at once instead of waiting for the counter to wrap.
          tick_d = 1'b1;
          // >= so a seq_len lowered below the current step wraps next tick.
          idx_d  = (step_idx >= seq_len) ? '0 : step_idx + STEP_W'(1);
        end
      end
      default: begin
        stop_d = 1'b1;
      end
    endcase

    // A tick into step 0 uses the live pattern, which is also what the
    // shadow captures on that same edge.
    shadow_d = (tick_d && (idx_d == '0)) ? pattern : shadow;
  end

  assign fire = tick_d && shadow_d[idx_d];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      div_cnt   <= '0;
      step_idx  <= '0;
      shadow    <= '0;
      step_tick <= 1'b0;
      bar_start <= 1'b0;
      running   <= 1'b0;
    end else begin
      shadow    <= shadow_d;
      step_tick <= tick_d;
      bar_start <= tick_d && (idx_d == '0);
      if (stop_d) begin
        state    <= ST_IDLE;
        div_cnt  <= '0;
        step_idx <= '0;
        running  <= 1'b0;
      end else if (tick_d) begin
        state    <= ST_RUN;
        div_cnt  <= '0;
        step_idx <= idx_d;
        running  <= 1'b1;
      end else if (state == ST_RUN) begin
        div_cnt  <= div_cnt + DIV_WIDTH'(1);
      end
    end
  end

  // Stopping cuts the voice off immediately rather than letting it ring out.
  seq_trig_stretch #(
    .TRIG_LEN(TRIG_LEN)
  ) u_trig (
    .clk  (clk),
    .reset(reset),
    .fire (fire),
    .kill (stop_d),
    .pulse(trig)
  );

endmodule

// File: doc/seq_step_player.md
Name: seq_step_player

Overview:
- Hardware consumer of the 32-bit clap pattern that the NIOS II writes through its PIO output port.
- Walks the pattern one step at a time at a programmable tempo and emits a fixed-length trigger pulse for every set bit.
- Output drives the clap voice envelope; step index is exported for LEDs and cross-track sync.
- Pattern is double-buffered: CPU writes take effect only at bar start, so a mid-bar write never glitches the bar.

Parameters:
- NUM_STEPS, 32, maximum steps per bar; equals pattern width.
- STEP_W, 5, width of step index; equals log2(NUM_STEPS).
- DIV_WIDTH, 24, width of the tempo divider.
- TRIG_LEN, 64, trigger pulse length in clk cycles; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = play, 0 = stop and rewind.
- restart  in  1  one-cycle pulse; rewind to step 0 while running.
- step_div  in  DIV_WIDTH  clk cycles per step minus 1.
- seq_len  in  STEP_W  bar length minus 1 (0..31 → 1..32 steps).
- pattern  in  NUM_STEPS  live pattern from PIO; bit n = step n.
- trig  out  1  trigger pulse to voice.
- step_tick  out  1  one-cycle strobe at the start of each step.
- bar_start  out  1  one-cycle strobe coincident with the step_tick of step 0.
- step_idx  out  STEP_W  index of the current step.
- running  out  1  high while in RUN.

Behaviour:
- Reset: state IDLE; div_cnt=0, step_idx=0, shadow=0, trig counter=0; all outputs 0.
- All outputs are registered.
- IDLE: counters held at 0.
  - run=1 sampled at edge N → state=RUN at N+1.
  - At N+1: shadow←pattern, step_idx=0, step_tick=1, bar_start=1, running=1.
  - trig=1 at N+1 if pattern[0]=1.
- RUN: div_cnt increments each cycle after a tick.
  - When div_cnt ≥ step_div (live value, so a shrinking step_div ends the step next cycle), the next cycle is a step tick: div_cnt←0.
  - step_idx←0 if step_idx ≥ seq_len, else step_idx+1.
  - Tick spacing is step_div+1 cycles; step_div=0 gives a tick every cycle.
- Wrap: on any tick to step 0, shadow←pattern sampled the same edge; bar_start=1 with that tick.
  - seq_len lowered below step_idx: next tick wraps to 0.
- Trigger: on a tick with shadow[step_idx_new]=1, trig rises with step_tick and stays high TRIG_LEN cycles.
  - A new qualifying tick while trig is high reloads the counter (retrigger; no low gap).
  - A non-qualifying tick does not truncate an active pulse.
- restart=1 in RUN: next cycle is a step-0 tick (fresh shadow, div_cnt=0, bar_start=1). restart in IDLE is ignored.
- run=0 in RUN: next cycle state=IDLE.
  - trig, step_tick, bar_start, running = 0; step_idx=0.
  - The active pulse is truncated.
  - run=0 overrides a simultaneous restart=1.
- reset mid-operation: same as the reset state on the next cycle, regardless of trig or state.
- pattern, step_div and seq_len are quasi-static CPU registers in the same clock domain; no synchronizers.

Decomposition:
- Shared sequencer package holds:
  - NUM_STEPS, STEP_W and the state encoding (IDLE=0, RUN=1).
  - It is reused by the kick, snare and hat players.
- One sub-module, seq_trig_stretch: retriggerable pulse stretcher with inputs clk, reset, fire, kill and output pulse.
  - Parameter TRIG_LEN.
  - Counter width clog2(TRIG_LEN+1).

Test Plan:
- Basic pattern: reset 4 cycles; pattern=32'h0000_0005, step_div=3, seq_len=3, TRIG_LEN=2, run=1 → ticks every 4 cycles; trig high 2 cycles at steps 0 and 2 only; step_idx 0,1,2,3,0; bar_start every 16 cycles.
- Double buffer: mid-bar at step 1, write pattern=32'h0000_0002 → step 1 of the current bar silent; step 1 of the next bar triggers.
- Retrigger: TRIG_LEN=10, step_div=3, pattern=32'hFFFF_FFFF → trig stays continuously high, with no low cycle, for as long as run=1.
- Stop mid-pulse: with trig high, drop run → next cycle trig=0, running=0, step_idx=0. Raise run → step-0 tick exactly 1 cycle later.
- Restart and length: seq_len=31, at step 20 pulse restart → next cycle step_idx=0, bar_start=1. Then set seq_len=4 at step 7 → next tick goes to step 0.
- Edge cases: step_div=0 → step_tick every cycle and step_idx increments every cycle. Assert reset mid-RUN → all outputs 0 the next cycle.
